// File: rtl/multi_edge_detector.sv
// Per-channel synchronizer, glitch filter and edge detector with Mode-qualified
// sticky pending flags, a saturating event counter and a combined interrupt.
module multi_edge_detector #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int CNT_W       = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N-1:0]     A,
  input  logic [2*N-1:0]   Mode,
  input  logic [N-1:0]     Clear,
  input  logic             Count_Clr,
  output logic [N-1:0]     Rising_Edge,
  output logic [N-1:0]     Falling_Edge,
  output logic [N-1:0]     Event_Pending,
  output logic [CNT_W-1:0] Event_Count,
  output logic             Irq
);

  localparam int FCW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int SUM_W = CNT_W + $clog2(N + 1) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [N-1:0]     synced;
  logic [N-1:0]     filt_q, filt_d;
  logic [N-1:0]     filt_dly_q;
  logic [FCW-1:0]   stab_q [N];
  logic [FCW-1:0]   stab_d [N];
  logic [N-1:0]     rise_q, rise_d;
  logic [N-1:0]     fall_q, fall_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [N-1:0]     qual;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SUM_W-1:0] sum;

  assign synced = sync_q[SYNC_STAGES-1];

  // The filtered level flips only after FILTER_LEN consecutive disagreeing
  // cycles; the pulses are taken from the filtered level one stage later.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < N; i++) begin
      stab_d[i] = '0;
      if (synced[i] != filt_q[i]) begin
        if (stab_q[i] == FCW'(FILTER_LEN - 1)) begin
          filt_d[i] = ~filt_q[i];
        end else begin
          stab_d[i] = stab_q[i] + FCW'(1);
        end
      end
    end
    rise_d = filt_q & ~filt_dly_q;
    fall_d = ~filt_q & filt_dly_q;
  end

  always_comb begin
    qual = '0;
    for (int i = 0; i < N; i++) begin
      qual[i] = (rise_q[i] & Mode[2*i]) | (fall_q[i] & Mode[2*i+1]);
    end
    // A new event wins over a same-cycle clear.
    pend_d = (pend_q & ~Clear) | qual;
    sum    = Count_Clr ? '0 : SUM_W'(count_q);
    for (int i = 0; i < N; i++) begin
      sum = sum + SUM_W'(qual[i]);
    end
    count_d = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < N; i++) stab_q[i] <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      pend_q     <= '0;
      count_q    <= '0;
    end else begin
      sync_q[0] <= A;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < N; i++) stab_q[i] <= stab_d[i];
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      pend_q     <= pend_d;
      count_q    <= count_d;
    end
  end

  assign Rising_Edge   = rise_q;
  assign Falling_Edge  = fall_q;
  assign Event_Pending = pend_q;
  assign Event_Count   = count_q;
  assign Irq           = |pend_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed and randomized checks of multi_edge_detector against a queue-based
// reference model of the synchronize / filter / qualify / count rules.
module tb_multi_edge_detector;

  localparam int N    = 4;
  localparam int SS   = 2;
  localparam int FL   = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [N-1:0]    A;
  logic [2*N-1:0]  Mode;
  logic [N-1:0]    Clear;
  logic            Count_Clr;
  logic [N-1:0]    Rising_Edge;
  logic [N-1:0]    Falling_Edge;
  logic [N-1:0]    Event_Pending;
  logic [CW-1:0]   Event_Count;
  logic            Irq;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [N-1:0] m_line[$];
  logic [N-1:0] m_f, m_rise, m_fall, m_tr, m_tf, m_pend;
  int           m_run[N];
  int           m_cnt;

  multi_edge_detector #(.N(N), .SYNC_STAGES(SS), .FILTER_LEN(FL), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .A(A), .Mode(Mode), .Clear(Clear), .Count_Clr(Count_Clr),
    .Rising_Edge(Rising_Edge), .Falling_Edge(Falling_Edge),
    .Event_Pending(Event_Pending), .Event_Count(Event_Count), .Irq(Irq)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_line.delete();
    for (int s = 0; s < SS; s++) m_line.push_back('0);
    m_f = '0; m_rise = '0; m_fall = '0; m_tr = '0; m_tf = '0; m_pend = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_cnt = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs the DUT sampled.
  task automatic model_edge();
    logic [N-1:0] rm, fm, qual, synced;
    if (Rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        rm[i] = Mode[2*i];
        fm[i] = Mode[2*i+1];
      end
      qual   = (m_rise & rm) | (m_fall & fm);
      m_pend = (m_pend & ~Clear) | qual;
      m_cnt  = (Count_Clr ? 0 : m_cnt) + $countones(qual);
      if (m_cnt > CMAX) m_cnt = CMAX;
      m_rise = m_tr;
      m_fall = m_tf;
      m_tr   = '0;
      m_tf   = '0;
      synced = m_line[0];
      for (int i = 0; i < N; i++) begin
        if (synced[i] != m_f[i]) begin
          m_run[i]++;
          if (m_run[i] == FL) begin
            m_f[i]   = ~m_f[i];
            m_run[i] = 0;
            if (m_f[i]) m_tr[i] = 1'b1;
            else        m_tf[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      void'(m_line.pop_front());
      m_line.push_back(A);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check("rise",  32'(Rising_Edge),   32'(m_rise));
    check("fall",  32'(Falling_Edge),  32'(m_fall));
    check("pend",  32'(Event_Pending), 32'(m_pend));
    check("count", 32'(Event_Count),   32'(m_cnt));
    check("irq",   32'(Irq),           32'(|m_pend));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    model_reset();
    Rst = 1'b1; A = '0; Mode = '0; Clear = '0; Count_Clr = 1'b0;
    run(2);
    check("reset_count", 32'(Event_Count), 32'd0);
    check("reset_irq",   32'(Irq),         32'd0);
    Rst = 1'b0;
    run(2);

    // Channel 0 rise, qualified: pulse after 5 edges from first sample
    Mode = 8'b0000_0001;
    A    = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 5) check("ch0_rise_early", 32'(Rising_Edge), 32'd0);
      if (k == 6) check("ch0_rise_pulse", 32'(Rising_Edge), 32'b0001);
      if (k == 7) check("ch0_rise_gone",  32'(Rising_Edge), 32'd0);
    end
    check("ch0_pend",  32'(Event_Pending), 32'b0001);
    check("ch0_count", 32'(Event_Count),   32'd1);
    check("ch0_irq",   32'(Irq),           32'd1);

    // Two-cycle glitch on channel 1 is filtered out
    Mode = 8'b0000_1101;
    A    = 4'b0011;
    run(2);
    A    = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step();
      check("ch1_no_rise", 32'(Rising_Edge[1]), 32'd0);
    end
    check("ch1_count", 32'(Event_Count), 32'd1);

    // Channel 2 fall-only qualification
    Mode = 8'b0010_1101;
    A    = 4'b0101;
    run(6);
    A    = 4'b0001;
    run(12);
    check("ch2_count", 32'(Event_Count),   32'd2);
    check("ch2_pend",  32'(Event_Pending), 32'b0101);

    // Settle everything low and clear pending flags
    Mode = '0;
    A    = '0;
    run(10);
    Clear = 4'hF;
    run(1);
    Clear = '0;
    run(2);
    check("cleared_pend", 32'(Event_Pending), 32'd0);

    // All channels rise together; Clear[0] on the pulse cycle loses to the event
    Mode = 8'hFF;
    A    = 4'hF;
    run(6);
    check("all_rise", 32'(Rising_Edge), 32'hF);
    Clear = 4'b0001;
    run(1);
    Clear = '0;
    check("all_pend",  32'(Event_Pending), 32'hF);
    check("all_count", 32'(Event_Count),   32'd6);

    // Saturation and Count_Clr
    for (int t = 0; t < 4; t++) begin
      A = ~A;
      run(8);
    end
    check("sat_count", 32'(Event_Count), 32'd15);
    Count_Clr = 1'b1;
    run(1);
    Count_Clr = 1'b0;
    check("cnt_clr", 32'(Event_Count), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) A = N'($urandom_range(0, 15));
      if (k % 50 == 0) Mode = 8'($urandom_range(0, 255));
      Clear     = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
      Count_Clr = ($urandom_range(0, 19) == 0);
      Rst       = ($urandom_range(0, 149) == 0);
      step();
    end
    Rst = 1'b0; Clear = '0; Count_Clr = 1'b0;

    // Reset in the middle of channel 3 filtering
    Rst = 1'b1;
    A   = '0;
    run(1);
    Rst  = 1'b0;
    Mode = 8'hFF;
    run(8);
    A = 4'b1000;
    run(4);
    Rst = 1'b1;
    run(1);
    check("mid_rst_rise",  32'(Rising_Edge),   32'd0);
    check("mid_rst_pend",  32'(Event_Pending), 32'd0);
    check("mid_rst_count", 32'(Event_Count),   32'd0);
    check("mid_rst_irq",   32'(Irq),           32'd0);
    Rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 5) check("ch3_rise_early", 32'(Rising_Edge), 32'd0);
      if (k == 6) check("ch3_rise_pulse", 32'(Rising_Edge), 32'b1000);
    end
    check("ch3_count", 32'(Event_Count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Parameters
REQ-001 SHALL provide parameter N, default 4: number of independent input channels (N >= 1).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2: synchronizer flop depth per channel (>= 2).
REQ-003 SHALL provide parameter FILTER_LEN, default 3: consecutive stable cycles required to accept a level change (>= 1).
REQ-004 SHALL provide parameter CNT_W, default 4: width of the qualified-event counter.

Interface
REQ-005 SHALL have Clk, input, 1: sole clock; all flops on rising edge.
REQ-006 SHALL have Rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have A, input, N: asynchronous per-channel inputs.
REQ-008 SHALL have Mode, input, 2*N: per-channel qualifier, bits [2i+1:2i]; 00 off, 01 rise, 10 fall, 11 both.
REQ-009 SHALL have Clear, input, N: write-1-to-clear for Event_Pending.
REQ-010 SHALL have Count_Clr, input, 1: zeroes Event_Count.
REQ-011 SHALL have Rising_Edge, output, N: one-cycle pulse per accepted 0->1 transition.
REQ-012 SHALL have Falling_Edge, output, N: one-cycle pulse per accepted 1->0 transition.
REQ-013 SHALL have Event_Pending, output, N: sticky per-channel qualified-event flag.
REQ-014 SHALL have Event_Count, output, CNT_W: saturating total of qualified events.
REQ-015 SHALL have Irq, output, 1: OR of Event_Pending.

Function
REQ-016 Each A[i] SHALL pass through SYNC_STAGES flops before any other logic.
REQ-017 Per channel: filtered level F[i] plus a stability counter; counter increments while synced input != F[i], resets to 0 when equal.
REQ-018 F[i] SHALL toggle on the cycle the counter reaches FILTER_LEN; counter returns to 0 that cycle.
REQ-019 Excursions shorter than FILTER_LEN synced cycles SHALL produce no pulse and leave F[i] unchanged.
REQ-020 Latency: Rising_Edge/Falling_Edge registered, high exactly one cycle, asserted SYNC_STAGES+FILTER_LEN edges after first edge sampling the new A level.
REQ-021 Rising_Edge/Falling_Edge SHALL pulse regardless of Mode; Mode only qualifies events.
REQ-022 Qualified event on channel i: rise pulse with Mode bit 0 set, or fall pulse with Mode bit 1 set; Mode is applied combinationally in the same cycle.
REQ-023 Event_Pending[i] SHALL set on qualified event, clear on Clear[i]; simultaneous set and clear -> stays 1.
REQ-024 Event_Count SHALL add the number of qualified events in the cycle (0..N), saturating at 2^CNT_W-1, never wrapping.
REQ-025 Count_Clr with events same cycle -> Event_Count = that cycle's event count (saturated).
REQ-026 Irq SHALL be combinational OR of registered Event_Pending, no extra latency.

Reset
REQ-027 Rst high SHALL, at next edge, zero synchronizers, F, stability counters, pulses, Event_Pending, Event_Count; Irq = 0.
REQ-028 Rst mid-operation SHALL discard in-flight filter progress; if A still differs from 0 after release, the edge is reported after full latency per REQ-020.
REQ-029 Rst SHALL override Clear, Count_Clr and all events in the same cycle.

Verification (N=4, SYNC_STAGES=2, FILTER_LEN=3, CNT_W=4)
REQ-030 Reset, Mode[1:0]=01, A[0] 0->1 held -> Rising_Edge[0] high one cycle, 5 edges later; Event_Pending=0001, Event_Count=1, Irq=1.
REQ-031 A[1] high for 2 cycles only, Mode=11 -> no pulses on ch1, Event_Count unchanged, F[1]=0.
REQ-032 Ch2 Mode=10, A[2] 0->1->0 each held 6 cycles -> both pulses appear, only fall qualifies; Event_Count +1.
REQ-033 All channels Mode=11, A 0000->1111 same cycle, Clear[0] asserted on pulse cycle -> Event_Count +4 in one cycle, Event_Pending=1111.
REQ-034 20 qualified events -> Event_Count reaches 15 and holds; Count_Clr with no event -> 0.
REQ-035 Rst pulsed 1 cycle while ch3 filter count = 2 -> all outputs 0; A[3] held 1 gives Rising_Edge[3] exactly 5 edges after Rst release.
